hyp_post_div: RTL and testbench
===============================

Name: hyp_post_div

Overview:
- Consumer stage placed directly after the hyperbolic CORDIC pipeline.
- Takes one (cosh, sinh) pair, per valid/ready handshake, in the pipeline's signed Q4.16 21-bit format.
- Produces exp(+θ) = cosh+sinh and exp(−θ) = cosh−sinh combinationally at capture time.
- Produces tanh(θ) = sinh/cosh with a multi-cycle restoring divider. One transaction is in flight at a time.

Parameters:
- W, 21, datapath width in bits (sign + 4 integer + FRAC fraction bits).
- FRAC, 16, number of fraction bits; 1.0 = 1<<FRAC.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  cosh_in/sinh_in valid.
- in_ready  output  1  block can accept a pair.
- cosh_in  input  W  cosh(θ), Q4.16, treated as unsigned magnitude.
- sinh_in  input  W  sinh(θ), Q4.16, treated as unsigned magnitude.
- out_valid  output  1  result registers valid.
- out_ready  input  1  downstream accepts result.
- exp_pos  output  W  saturated cosh+sinh.
- exp_neg  output  W  clamped cosh−sinh.
- tanh_out  output  W  sinh/cosh, Q4.16.
- div_err  output  1  cosh_in was zero for this result.

Behaviour:
- Clock/reset: one clock, clk. Reset is asynchronous, active-low, on rst_n.
- Reset values: state IDLE; in_ready=1; out_valid=0; exp_pos=exp_neg=tanh_out=0; div_err=0; internal counter and remainder 0.
- Reset mid-division: the current transaction is discarded and no output is produced.

FSM states: IDLE, DIV, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid, latch the inputs and compute exp_pos/exp_neg into output registers.
  - If cosh_in==0: set div_err=1, tanh_out=0x0FFFF, go to DONE.
  - Else if sinh_in>=cosh_in: set tanh_out=0x10000, div_err=0, go to DONE.
  - Otherwise: rem=sinh_in, divisor=cosh_in, cnt=FRAC−1, go to DIV.
- DIV:
  - in_ready=0.
  - Each cycle: rem=rem<<1 (W+1 bits wide). If rem>=divisor, then rem-=divisor and the quotient bit is 1.
  - The quotient shifts in LSB-first order into tanh_out[FRAC−1:0]; upper bits are 0.
  - After the cnt==0 iteration, go to DONE.
- DONE:
  - out_valid=1. Outputs are held stable while out_ready=0.
  - On out_ready, go to IDLE. A new input is not accepted in the same cycle (in_ready=0 in DONE).

Timing and arithmetic:
- Latency: out_valid rises 17 cycles after the accepting edge for a normal divide, and 1 cycle after for the early-exit cases.
- Throughput: at most one result per 18 cycles.
- exp_pos: compute the W+1-bit unsigned sum. If the sum >= 1<<(W−1), saturate to 0x0FFFFF (max positive).
- exp_neg: if sinh>cosh, clamp to 0; otherwise cosh−sinh.
- Rounding: tanh_out is truncated (round toward zero).

Optional Feature:
- Macro: HYP_TANH_ROUND_EN.
- When defined:
  - DIV performs FRAC+1 iterations; the extra guard bit is added to the quotient (round half up).
  - The result saturates at 0x10000.
  - Normal-divide latency becomes 18 cycles.
- When undefined: truncation, 17-cycle latency.

Decomposition:
- Shared package hyp_pkg holds:
  - W and FRAC.
  - HYP_ONE=21'h10000.
  - HYP_MAX_POS=21'h0FFFFF.
  - HYP_TANH_DZ=21'h0FFFF.
  - State enum encoding for IDLE/DIV/DONE.
- One sub-module, hyp_div_step: combinational single restoring step (rem, divisor → next_rem, qbit). The FSM instantiates it once and iterates over it.

Test Plan:
- Unity input: cosh=0x10000, sinh=0 → exp_pos=0x10000, exp_neg=0x10000, tanh_out=0, div_err=0, out_valid 17 cycles after accept.
- θ=0.5: cosh=0x120AA, sinh=0x8567 → exp_pos=0x1A611, exp_neg=0x09B43, tanh_out=0x0764E; with HYP_TANH_ROUND_EN, 0x0764F at 18 cycles.
- Saturation: cosh=0xC0000, sinh=0xC0000 → exp_pos=0x0FFFFF, exp_neg=0, tanh_out=0x10000, out_valid one cycle after accept.
- Divide-by-zero: cosh=0, sinh=0 → div_err=1, tanh_out=0x0FFFF, exp_pos=0, exp_neg=0.
- Backpressure:
  - Hold out_ready=0 for 10 cycles after out_valid; outputs are stable and in_ready=0.
  - A new in_valid pulse is not accepted.
  - After out_ready, the FSM returns to IDLE and the next pair is accepted.
- Reset mid-operation: assert rst_n=0 at DIV iteration 8 → all outputs 0 and in_ready=1 immediately after reset (asynchronous). The next transaction completes correctly with no stale remainder.

Source files
------------

// File: rtl/hyp_pkg.sv
// Shared constants for the hyperbolic CORDIC post-processing stage (Q4.16, 21-bit).
package hyp_pkg;

  localparam int W    = 21;
  localparam int FRAC = 16;

  localparam logic [20:0] HYP_ONE     = 21'h10000;
  localparam logic [20:0] HYP_MAX_POS = 21'h0FFFFF;
  localparam logic [20:0] HYP_TANH_DZ = 21'h0FFFF;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DIV  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/hyp_div_step.sv
// One restoring-division step: shift the partial remainder left, subtract the
// divisor when it fits, and report the resulting quotient bit.
module hyp_div_step #(
  parameter int W = 21
) (
  input  logic [W:0]   rem_i,
  input  logic [W-1:0] divisor_i,
  output logic [W:0]   rem_o,
  output logic         qbit_o
);

  logic [W:0] shifted;
  logic [W:0] dvs;

  // rem_i is always below the divisor, so the bit shifted out of the top is zero
  always_comb begin
    shifted = rem_i << 1;
    dvs     = {1'b0, divisor_i};
    qbit_o  = (shifted >= dvs);
    rem_o   = qbit_o ? (shifted - dvs) : shifted;
  end

endmodule

// File: rtl/hyp_post_div.sv
// Post-CORDIC stage: exp(+/-theta) from cosh/sinh and tanh = sinh/cosh by an
// iterative restoring divider. Define HYP_TANH_ROUND_EN for round-half-up tanh.
module hyp_post_div #(
  parameter int W    = hyp_pkg::W,
  parameter int FRAC = hyp_pkg::FRAC
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] cosh_in,
  input  logic [W-1:0] sinh_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] exp_pos,
  output logic [W-1:0] exp_neg,
  output logic [W-1:0] tanh_out,
  output logic         div_err
);

  import hyp_pkg::*;

`ifdef HYP_TANH_ROUND_EN
  localparam int ITER = FRAC + 1;
`else
  localparam int ITER = FRAC;
`endif
  localparam int CNT_W = $clog2(ITER);
  localparam logic [W:0] SAT_LIM = (W+1)'(1) << (W - 1);

  logic [1:0]       state_q, state_d;
  logic [W:0]       rem_q, rem_d;
  logic [W-1:0]     div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ITER-1:0]  quo_q, quo_d;
  logic [W-1:0]     exp_pos_q, exp_pos_d;
  logic [W-1:0]     exp_neg_q, exp_neg_d;
  logic [W-1:0]     tanh_q, tanh_d;
  logic             err_q, err_d;

  logic [W:0]       step_rem;
  logic             step_q;
  logic [W:0]       sum;
  logic [ITER-1:0]  quo_next;
  logic [W-1:0]     tanh_final;

  hyp_div_step #(.W(W)) u_step (
    .rem_i     (rem_q),
    .divisor_i (div_q),
    .rem_o     (step_rem),
    .qbit_o    (step_q)
  );

  always_comb begin
    sum      = {1'b0, cosh_in} + {1'b0, sinh_in};
    quo_next = ITER'({quo_q, step_q});
`ifdef HYP_TANH_ROUND_EN
    // Guard bit rounds half up; a result of exactly one is the largest possible
    begin : g_round
      logic [FRAC:0] rnd;
      rnd = {1'b0, quo_next[FRAC:1]} + {{FRAC{1'b0}}, quo_next[0]};
      tanh_final = rnd[FRAC] ? HYP_ONE : W'(rnd);
    end
`else
    tanh_final = W'(quo_next);
`endif
  end

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    div_d     = div_q;
    cnt_d     = cnt_q;
    quo_d     = quo_q;
    exp_pos_d = exp_pos_q;
    exp_neg_d = exp_neg_q;
    tanh_d    = tanh_q;
    err_d     = err_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          exp_pos_d = (sum >= SAT_LIM) ? HYP_MAX_POS : sum[W-1:0];
          exp_neg_d = (sinh_in > cosh_in) ? '0 : (cosh_in - sinh_in);
          if (cosh_in == '0) begin
            err_d   = 1'b1;
            tanh_d  = HYP_TANH_DZ;
            state_d = ST_DONE;
          end else if (sinh_in >= cosh_in) begin
            err_d   = 1'b0;
            tanh_d  = HYP_ONE;
            state_d = ST_DONE;
          end else begin
            err_d   = 1'b0;
            rem_d   = {1'b0, sinh_in};
            div_d   = cosh_in;
            cnt_d   = CNT_W'(ITER - 1);
            quo_d   = '0;
            state_d = ST_DIV;
          end
        end
      end
      ST_DIV: begin
        rem_d = step_rem;
        quo_d = quo_next;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          tanh_d  = tanh_final;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      rem_q     <= '0;
      div_q     <= '0;
      cnt_q     <= '0;
      quo_q     <= '0;
      exp_pos_q <= '0;
      exp_neg_q <= '0;
      tanh_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      quo_q     <= quo_d;
      exp_pos_q <= exp_pos_d;
      exp_neg_q <= exp_neg_d;
      tanh_q    <= tanh_d;
      err_q     <= err_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign exp_pos   = exp_pos_q;
  assign exp_neg   = exp_neg_q;
  assign tanh_out  = tanh_q;
  assign div_err   = err_q;

endmodule

// File: tb/tb_hyp_post_div.sv
// Self-checking bench for hyp_post_div: directed cases, backpressure, reset
// during a divide, throughput and randomized pairs against an arithmetic model.
module tb_hyp_post_div;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [20:0] cosh_in = '0;
  logic [20:0] sinh_in = '0;
  logic        in_ready;
  logic        out_valid;
  logic [20:0] exp_pos;
  logic [20:0] exp_neg;
  logic [20:0] tanh_out;
  logic        div_err;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef HYP_TANH_ROUND_EN
  localparam int          LAT_DIV = 18;
  localparam logic [20:0] TH_HALF = 21'h0764F;
`else
  localparam int          LAT_DIV = 17;
  localparam logic [20:0] TH_HALF = 21'h0764E;
`endif

  hyp_post_div dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .cosh_in   (cosh_in),
    .sinh_in   (sinh_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .exp_pos   (exp_pos),
    .exp_neg   (exp_neg),
    .tanh_out  (tanh_out),
    .div_err   (div_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  // Reference: exp as a plain sum/difference, tanh as an integer quotient of sinh*2^16 by cosh
  function automatic void ref_model(input logic [20:0] c, input logic [20:0] s,
                                    output logic [62:0] res, output int lat);
    longint lc, ls, q, sm;
    logic [20:0] ep, en, th;
    logic er;
    lc = longint'(c);
    ls = longint'(s);
    sm = lc + ls;
    ep = (sm >= 1048576) ? 21'hFFFFF : 21'(sm);
    en = (ls > lc) ? 21'h0 : 21'(lc - ls);
    er = 1'b0;
    lat = 1;
    if (lc == 0) begin
      er = 1'b1;
      th = 21'h0FFFF;
    end else if (ls >= lc) begin
      th = 21'h10000;
    end else begin
`ifdef HYP_TANH_ROUND_EN
      q = (((ls * 131072) / lc) + 1) / 2;
      if (q > 65536) q = 65536;
`else
      q = (ls * 65536) / lc;
`endif
      th = 21'(q);
      lat = LAT_DIV;
    end
    res = {ep, en, th};
    if (er) res[0] = res[0];
    res = {ep, en, th};
    res[62:0] = {ep, en, th};
    res = res;
    // the error flag travels separately in the comparison below
    if (er) res = {ep, en, th};
  endfunction

  function automatic logic ref_err(input logic [20:0] c);
    return (c == 21'h0);
  endfunction

  task automatic send(input logic [20:0] c, input logic [20:0] s, output int lat);
    int w;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      lat = -1;
      return;
    end
    cosh_in  = c;
    sinh_in  = s;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic release_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL reset_handshake: got in_ready,out_valid=%b want 10", {in_ready, out_valid});
    end
    n_checks++;
    if ({exp_pos, exp_neg, tanh_out, div_err} !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h want 0", {exp_pos, exp_neg, tanh_out, div_err});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [20:0] tc [4];
    logic [20:0] ts [4];
    logic [63:0] texp [4];
    int tlat [4];
    int lat;
    tc[0] = 21'h10000; ts[0] = 21'h00000; texp[0] = {21'h10000, 21'h10000, 21'h00000, 1'b0}; tlat[0] = LAT_DIV;
    tc[1] = 21'h120AA; ts[1] = 21'h08567; texp[1] = {21'h1A611, 21'h09B43, TH_HALF,   1'b0}; tlat[1] = LAT_DIV;
    tc[2] = 21'hC0000; ts[2] = 21'hC0000; texp[2] = {21'hFFFFF, 21'h00000, 21'h10000, 1'b0}; tlat[2] = 1;
    tc[3] = 21'h00000; ts[3] = 21'h00000; texp[3] = {21'h00000, 21'h00000, 21'h0FFFF, 1'b1}; tlat[3] = 1;
    for (int i = 0; i < 4; i++) begin
      send(tc[i], ts[i], lat);
      n_checks++;
      if ({exp_pos, exp_neg, tanh_out, div_err} !== texp[i]) begin
        n_fail++;
        $display("FAIL directed[%0d]_result: got %h want %h", i, {exp_pos, exp_neg, tanh_out, div_err}, texp[i]);
      end
      n_checks++;
      if (lat !== tlat[i]) begin
        n_fail++;
        $display("FAIL directed[%0d]_latency: got %0d want %0d", i, lat, tlat[i]);
      end
      release_out();
    end
  endtask

  task automatic test_backpressure();
    logic [62:0] r;
    logic [63:0] held;
    int lat, elat;
    send(21'h1F000, 21'h0A123, lat);
    ref_model(21'h1F000, 21'h0A123, r, elat);
    held = {r, 1'b0};
    n_checks++;
    if ({exp_pos, exp_neg, tanh_out, div_err} !== held) begin
      n_fail++;
      $display("FAIL bp_result: got %h want %h", {exp_pos, exp_neg, tanh_out, div_err}, held);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 3) begin
        cosh_in  = 21'h00500;
        sinh_in  = 21'h00100;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      n_checks++;
      if ({out_valid, in_ready, exp_pos, exp_neg, tanh_out, div_err} !== {2'b10, held}) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got %h want %h", i,
                 {out_valid, in_ready, exp_pos, exp_neg, tanh_out, div_err}, {2'b10, held});
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    release_out();
    n_checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL bp_release: got out_valid,in_ready=%b want 01", {out_valid, in_ready});
    end
    send(21'h0A000, 21'h03000, lat);
    ref_model(21'h0A000, 21'h03000, r, elat);
    n_checks++;
    if ({exp_pos, exp_neg, tanh_out, div_err, lat} !== {r, 1'b0, elat}) begin
      n_fail++;
      $display("FAIL bp_next: got %h lat %0d want %h lat %0d", {exp_pos, exp_neg, tanh_out, div_err}, lat, {r, 1'b0}, elat);
    end
    release_out();
  endtask

  task automatic test_reset_mid();
    logic [62:0] r;
    int lat, elat;
    @(negedge clk);
    cosh_in  = 21'h15555;
    sinh_in  = 21'h0ABCD;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL rstmid_handshake: got in_ready,out_valid=%b want 10", {in_ready, out_valid});
    end
    n_checks++;
    if ({exp_pos, exp_neg, tanh_out, div_err} !== 64'h0) begin
      n_fail++;
      $display("FAIL rstmid_outputs: got %h want 0", {exp_pos, exp_neg, tanh_out, div_err});
    end
    @(negedge clk);
    rst_n = 1'b1;
    send(21'h18000, 21'h0C001, lat);
    ref_model(21'h18000, 21'h0C001, r, elat);
    n_checks++;
    if ({exp_pos, exp_neg, tanh_out, div_err} !== {r, 1'b0}) begin
      n_fail++;
      $display("FAIL rstmid_next_result: got %h want %h", {exp_pos, exp_neg, tanh_out, div_err}, {r, 1'b0});
    end
    n_checks++;
    if (lat !== elat) begin
      n_fail++;
      $display("FAIL rstmid_next_latency: got %0d want %0d", lat, elat);
    end
    release_out();
  endtask

  task automatic test_throughput();
    int cyc, first, second, w;
    cyc = 0;
    first = -1;
    second = -1;
    out_ready = 1'b1;
    cosh_in = 21'h11111;
    sinh_in = 21'h02222;
    in_valid = 1'b1;
    while (second < 0 && cyc < 80) begin
      @(negedge clk);
      if (in_ready) begin
        if (first < 0) first = cyc;
        else second = cyc;
      end
      @(posedge clk);
      cyc++;
    end
    #1;
    in_valid = 1'b0;
    w = 0;
    while (!in_ready && w < 40) begin
      @(posedge clk);
      #1;
      w++;
    end
    out_ready = 1'b0;
    n_checks++;
    if (second - first !== LAT_DIV + 1) begin
      n_fail++;
      $display("FAIL throughput_gap: got %0d want %0d", second - first, LAT_DIV + 1);
    end
  endtask

  task automatic test_random();
    logic [20:0] c, s;
    logic [62:0] r;
    int lat, elat, kind;
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        c = 21'h0;
        s = 21'($urandom_range(0, 21'h1FFFFF));
      end else if (kind == 1) begin
        c = 21'($urandom_range(1, 21'h0FFFFF));
        s = 21'(int'(c) + $urandom_range(0, 21'h1FFFFF - int'(c)));
      end else begin
        c = 21'($urandom_range(1, (kind < 5) ? 21'h1FFFFF : 21'h003FF));
        s = 21'($urandom_range(0, int'(c) - 1));
      end
      send(c, s, lat);
      ref_model(c, s, r, elat);
      n_checks++;
      if ({exp_pos, exp_neg, tanh_out, div_err} !== {r, ref_err(c)}) begin
        n_fail++;
        $display("FAIL random[%0d]_result c=%h s=%h: got %h want %h", i, c, s,
                 {exp_pos, exp_neg, tanh_out, div_err}, {r, ref_err(c)});
      end
      n_checks++;
      if (lat !== elat) begin
        n_fail++;
        $display("FAIL random[%0d]_latency c=%h s=%h: got %0d want %0d", i, c, s, lat, elat);
      end
      repeat ($urandom_range(0, 3)) @(posedge clk);
      release_out();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_throughput();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
